arith_issue_queue: RTL and testbench
====================================

ARITH_ISSUE_QUEUE -- requirements
Module: arith_issue_queue

Interface
REQ-001 SHALL have parameters: INST_ID_BITS, default 6, instruction tag width; PRN_BITS, default 6, physical register number width; MAX_OPERANDS, default 3, source/destination slots; DEPTH, default 4, entry count (2..8).
REQ-002 SHALL have ports, in this order:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- flush  in  1  synchronous clear of all entries
- in_valid  in  1  dispatch request
- in_ready  out  1  entry available
- in_inst_id  in  INST_ID_BITS  tag
- in_inst  in  32  instruction word
- in_pc  in  64  PC
- in_src_used  in  MAX_OPERANDS x 1  source slot used
- in_src_prn  in  MAX_OPERANDS x PRN_BITS  source PRNs
- in_src_rdy  in  MAX_OPERANDS x 1  source value already available
- in_src_data  in  MAX_OPERANDS x 64  value when in_src_rdy
- in_out_prn  in  MAX_OPERANDS x PRN_BITS  destination PRNs
- wb_valid  in  1  writeback broadcast valid
- wb_prn  in  PRN_BITS  broadcast PRN
- wb_data  in  64  broadcast value
- fu_ready  in  1  downstream FU accepts this cycle
- inst_valid  out  1  issue valid
- inst_id  out  INST_ID_BITS
- inst  out  32
- pc  out  64
- op  out  MAX_OPERANDS x 64  operand values
- out_prn  out  MAX_OPERANDS x PRN_BITS
- count  out  $clog2(DEPTH+1)  occupied entries

Function
REQ-003 Storage SHALL be a compacting array, entry 0 oldest; valid entries always contiguous from index 0; count equals the valid-entry total.
REQ-004 in_ready SHALL equal (count < DEPTH) and not flush; no same-cycle slot reuse when full.
REQ-005 Enqueue on in_valid and in_ready at clock edge; entry written at index count minus one if an issue fires that cycle, else at index count.
REQ-006 Per source at enqueue: in_src_used=0 -> ready, data 0; in_src_rdy=1 -> ready, data in_src_data; else if wb_valid and wb_prn==in_src_prn -> ready, data wb_data (same-cycle bypass); else not ready.
REQ-007 Wakeup: each cycle wb_valid, every valid entry source not ready with matching PRN SHALL become ready and capture wb_data at that edge; multiple matches all captured.
REQ-008 Entry eligible when valid and all sources ready; inst_valid SHALL equal fu_ready and any entry eligible, combinational from registered state.
REQ-009 Selection SHALL be the lowest-index eligible entry; inst_id, inst, pc, op, out_prn SHALL show that entry's fields; when inst_valid=0 these outputs SHALL be 0.
REQ-010 On edge with inst_valid=1, selected entry removed and younger entries shift down one index, preserving wakeup updates made at the same edge.
REQ-011 Latency: enqueue with all sources ready at edge N -> inst_valid in cycle N+1 if fu_ready; wakeup at edge N -> issue earliest cycle N+1.
REQ-012 fu_ready=0 SHALL hold all entries; no issue, no age change.
REQ-013 flush=1 SHALL invalidate all entries at the edge, override enqueue and issue; inst_valid SHALL be 0 during flush cycle.
REQ-014 Simultaneous enqueue, issue and wakeup in one cycle SHALL all take effect; count changes by +1, 0 or -1 accordingly.

Reset
REQ-015 rst=1 SHALL immediately clear all entries, count=0, inst_valid=0, all issue outputs 0, in_ready=1 after release; any in-flight entries discarded.

Verification
REQ-016 Enqueue inst_id=5, all sources rdy, fu_ready=1 -> inst_valid next cycle, inst_id=5, count back to 0.
REQ-017 Enqueue id=1 src0 prn=9 not ready, then id=2 all ready -> id=2 issues first; wb prn=9 data=0xABCD -> id=1 issues next cycle with op[0]=0xABCD.
REQ-018 Fill 4 entries with fu_ready=0 -> in_ready=0, count=4; in_valid held causes no write; fu_ready=1 -> issues ids in order 0,1,2,3.
REQ-019 Enqueue with src prn=3 while wb_valid prn=3 data=7 same cycle -> entry ready, op value 7.
REQ-020 Queue with 3 entries, flush=1 -> count=0, inst_valid=0 next cycle; rst asserted mid-stream -> outputs 0 asynchronously.

Source files
------------

// File: rtl/arith_issue_queue.sv
// Arithmetic issue queue: a compacting age-ordered array of pending operations.
// Entry 0 is the oldest; live entries always occupy indices [0, count).
// Sources wake up from a single writeback broadcast; the oldest entry whose
// sources are all ready is issued, and every younger entry shifts down one slot.
module arith_issue_queue #(
   parameter int INST_ID_BITS = 6,
   parameter int PRN_BITS     = 6,
   parameter int MAX_OPERANDS = 3,
   parameter int DEPTH        = 4
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    flush,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   input  logic [INST_ID_BITS-1:0]                 in_inst_id,
   input  logic [31:0]                             in_inst,
   input  logic [63:0]                             in_pc,
   input  logic [MAX_OPERANDS-1:0]                 in_src_used,
   input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   in_src_prn,
   input  logic [MAX_OPERANDS-1:0]                 in_src_rdy,
   input  logic [MAX_OPERANDS-1:0][63:0]           in_src_data,
   input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   in_out_prn,
   input  logic                                    wb_valid,
   input  logic [PRN_BITS-1:0]                     wb_prn,
   input  logic [63:0]                             wb_data,
   input  logic                                    fu_ready,
   output logic                                    inst_valid,
   output logic [INST_ID_BITS-1:0]                 inst_id,
   output logic [31:0]                             inst,
   output logic [63:0]                             pc,
   output logic [MAX_OPERANDS-1:0][63:0]           op,
   output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   out_prn,
   output logic [$clog2(DEPTH+1)-1:0]              count
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int IW = $clog2(DEPTH);

   typedef struct packed {
      logic [INST_ID_BITS-1:0]               id;
      logic [31:0]                           inst;
      logic [63:0]                           pc;
      logic [MAX_OPERANDS-1:0]               rdy;
      logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] prn;
      logic [MAX_OPERANDS-1:0][63:0]         data;
      logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] oprn;
   } entry_t;

   entry_t        r_q [DEPTH];
   logic [CW-1:0] r_count;

   // w_up carries one extra all-zero slot so the top entry can shift in "nothing"
   entry_t        w_up [DEPTH+1];
   entry_t        w_nx [DEPTH];
   entry_t        w_new;
   logic [DEPTH-1:0] w_elig;
   logic [IW-1:0] w_sel;
   logic          w_any;
   logic          w_issue;
   logic          w_enq;
   logic [CW-1:0] w_wr_idx;
   logic [CW-1:0] w_cnt_nxt;

   assign in_ready = (r_count < CW'(DEPTH)) && !flush;
   assign w_enq    = in_valid && in_ready;
   assign w_issue  = fu_ready && w_any && !flush;
   assign count    = r_count;

   // eligibility and oldest-first selection, purely from registered state
   always_comb begin
      w_elig = '0;
      w_sel  = '0;
      w_any  = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         w_elig[i] = (CW'(i) < r_count) && (&r_q[i].rdy);
      end
      for (int i = DEPTH-1; i >= 0; i--) begin
         if (w_elig[i]) begin
            w_sel = IW'(i);
            w_any = 1'b1;
         end
      end
   end

   // issue outputs are forced to zero whenever nothing issues
   always_comb begin
      inst_valid = w_issue;
      inst_id    = '0;
      inst       = '0;
      pc         = '0;
      op         = '0;
      out_prn    = '0;
      if (w_issue) begin
         inst_id = r_q[w_sel].id;
         inst    = r_q[w_sel].inst;
         pc      = r_q[w_sel].pc;
         op      = r_q[w_sel].data;
         out_prn = r_q[w_sel].oprn;
      end
   end

   // new entry, with same-cycle writeback bypass for sources still outstanding
   always_comb begin
      w_new      = '0;
      w_new.id   = in_inst_id;
      w_new.inst = in_inst;
      w_new.pc   = in_pc;
      w_new.prn  = in_src_prn;
      w_new.oprn = in_out_prn;
      for (int s = 0; s < MAX_OPERANDS; s++) begin
         if (!in_src_used[s]) begin
            w_new.rdy[s]  = 1'b1;
            w_new.data[s] = '0;
         end else if (in_src_rdy[s]) begin
            w_new.rdy[s]  = 1'b1;
            w_new.data[s] = in_src_data[s];
         end else if (wb_valid && (wb_prn == in_src_prn[s])) begin
            w_new.rdy[s]  = 1'b1;
            w_new.data[s] = wb_data;
         end else begin
            w_new.rdy[s]  = 1'b0;
            w_new.data[s] = '0;
         end
      end
   end

   // wakeup first, then compaction, then the enqueue write on top
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         w_up[i] = r_q[i];
         for (int s = 0; s < MAX_OPERANDS; s++) begin
            if (wb_valid && !r_q[i].rdy[s] && (r_q[i].prn[s] == wb_prn)) begin
               w_up[i].rdy[s]  = 1'b1;
               w_up[i].data[s] = wb_data;
            end
         end
      end
      w_up[DEPTH] = '0;

      for (int i = 0; i < DEPTH; i++) begin
         if (w_issue && (IW'(i) >= w_sel)) begin
            w_nx[i] = w_up[i+1];
         end else begin
            w_nx[i] = w_up[i];
         end
      end

      // an issue this edge frees a slot below the tail, so the write lands one lower
      w_wr_idx = r_count - CW'(w_issue);
      for (int i = 0; i < DEPTH; i++) begin
         if (w_enq && (CW'(i) == w_wr_idx)) begin
            w_nx[i] = w_new;
         end
      end

      if (flush) begin
         w_cnt_nxt = '0;
      end else begin
         w_cnt_nxt = r_count + CW'(w_enq) - CW'(w_issue);
      end
   end

   // entry storage and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_q[i] <= '0;
         end
      end else begin
         r_count <= w_cnt_nxt;
         for (int i = 0; i < DEPTH; i++) begin
            r_q[i] <= w_nx[i];
         end
      end
   end

endmodule

// File: tb/tb_arith_issue_queue.sv
// Directed bench for arith_issue_queue with hand-computed expectations.
module tb_arith_issue_queue;

   logic              clk = 1'b0;
   logic              rst, flush, in_valid, in_ready;
   logic [5:0]        in_inst_id;
   logic [31:0]       in_inst;
   logic [63:0]       in_pc;
   logic [2:0]        in_src_used, in_src_rdy;
   logic [2:0][5:0]   in_src_prn, in_out_prn;
   logic [2:0][63:0]  in_src_data;
   logic              wb_valid;
   logic [5:0]        wb_prn;
   logic [63:0]       wb_data;
   logic              fu_ready;
   logic              inst_valid;
   logic [5:0]        inst_id;
   logic [31:0]       inst;
   logic [63:0]       pc;
   logic [2:0][63:0]  op;
   logic [2:0][5:0]   out_prn;
   logic [2:0]        count;

   int n_cmp = 0;
   int n_err = 0;

   arith_issue_queue dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_inst_id(in_inst_id), .in_inst(in_inst), .in_pc(in_pc),
      .in_src_used(in_src_used), .in_src_prn(in_src_prn), .in_src_rdy(in_src_rdy),
      .in_src_data(in_src_data), .in_out_prn(in_out_prn),
      .wb_valid(wb_valid), .wb_prn(wb_prn), .wb_data(wb_data), .fu_ready(fu_ready),
      .inst_valid(inst_valid), .inst_id(inst_id), .inst(inst), .pc(pc),
      .op(op), .out_prn(out_prn), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // advance past the next rising edge; inputs set afterwards apply to the following edge
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive(input logic [5:0] id, input logic [2:0] used, input logic [2:0] rdy,
                        input logic [5:0] prn0, input logic [63:0] d0);
      in_valid       = 1'b1;
      in_inst_id     = id;
      in_inst        = {26'h0, id} | 32'hA000_0000;
      in_pc          = {58'h0, id} << 2;
      in_src_used    = used;
      in_src_rdy     = rdy;
      in_src_prn     = {6'd12, 6'd11, prn0};
      in_src_data    = {d0 + 64'd2, d0 + 64'd1, d0};
      in_out_prn     = {6'd3, 6'd2, 6'd1};
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst_id = '0; in_inst = '0; in_pc = '0;
      in_src_used = '0; in_src_rdy = '0; in_src_prn = '0; in_src_data = '0; in_out_prn = '0;
      wb_valid = 1'b0; wb_prn = '0; wb_data = '0; fu_ready = 1'b0;

      #12;
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_inst_valid", 64'(inst_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;

      // single fully-ready instruction issues the cycle after enqueue
      step();
      fu_ready = 1'b1;
      drive(6'd5, 3'b111, 3'b111, 6'd0, 64'h100);
      step();
      in_valid = 1'b0;
      settle();
      chk("r16_valid", 64'(inst_valid), 64'd1);
      chk("r16_id", 64'(inst_id), 64'd5);
      chk("r16_count", 64'(count), 64'd1);
      chk("r16_op0", op[0], 64'h100);
      chk("r16_op2", op[2], 64'h102);
      chk("r16_pc", pc, 64'd20);
      chk("r16_inst", 64'(inst), 64'hA000_0005);
      chk("r16_oprn1", 64'(out_prn[1]), 64'd2);
      step();
      settle();
      chk("r16_count0", 64'(count), 64'd0);
      chk("r16_idle", 64'(inst_valid), 64'd0);
      chk("r16_idle_id", 64'(inst_id), 64'd0);

      // waiting older entry is bypassed by a ready younger one, then wakes up
      drive(6'd1, 3'b001, 3'b000, 6'd9, 64'h0);
      step();
      drive(6'd2, 3'b000, 3'b000, 6'd0, 64'h0);
      settle();
      chk("r17_blocked", 64'(inst_valid), 64'd0);
      chk("r17_count1", 64'(count), 64'd1);
      step();
      in_valid = 1'b0;
      wb_valid = 1'b1; wb_prn = 6'd9; wb_data = 64'hABCD;
      settle();
      chk("r17_first_id", 64'(inst_id), 64'd2);
      chk("r17_first_op0", op[0], 64'd0);
      chk("r17_count2", 64'(count), 64'd2);
      step();
      wb_valid = 1'b0;
      settle();
      chk("r17_second_valid", 64'(inst_valid), 64'd1);
      chk("r17_second_id", 64'(inst_id), 64'd1);
      chk("r17_second_op0", op[0], 64'hABCD);
      chk("r17_second_op1", op[1], 64'd0);
      chk("r17_count_after", 64'(count), 64'd1);
      step();
      settle();
      chk("r17_empty", 64'(count), 64'd0);

      // fill while stalled, full back-pressure, then in-order drain
      fu_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(6'(k), 3'b111, 3'b111, 6'd0, 64'(k) * 64'h10);
         step();
      end
      drive(6'd7, 3'b111, 3'b111, 6'd0, 64'h0);
      settle();
      chk("r18_full_count", 64'(count), 64'd4);
      chk("r18_in_ready", 64'(in_ready), 64'd0);
      chk("r18_stall_valid", 64'(inst_valid), 64'd0);
      step();
      in_valid = 1'b0;
      settle();
      chk("r18_no_write", 64'(count), 64'd4);
      fu_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         settle();
         chk("r18_drain_valid", 64'(inst_valid), 64'd1);
         chk("r18_drain_id", 64'(inst_id), 64'(k));
         chk("r18_drain_op0", op[0], 64'(k) * 64'h10);
         chk("r18_drain_count", 64'(count), 64'(4 - k));
         step();
      end
      settle();
      chk("r18_drained", 64'(count), 64'd0);

      // same-cycle writeback bypass at dispatch
      fu_ready = 1'b0;
      drive(6'd8, 3'b001, 3'b000, 6'd3, 64'h0);
      wb_valid = 1'b1; wb_prn = 6'd3; wb_data = 64'd7;
      step();
      in_valid = 1'b0; wb_valid = 1'b0; fu_ready = 1'b1;
      settle();
      chk("r19_valid", 64'(inst_valid), 64'd1);
      chk("r19_id", 64'(inst_id), 64'd8);
      chk("r19_op0", op[0], 64'd7);
      step();

      // enqueue and issue in the same cycle keep the count steady
      drive(6'd10, 3'b111, 3'b111, 6'd0, 64'h50);
      step();
      drive(6'd11, 3'b111, 3'b111, 6'd0, 64'h60);
      settle();
      chk("r14_issue_id", 64'(inst_id), 64'd10);
      chk("r14_count_a", 64'(count), 64'd1);
      step();
      in_valid = 1'b0;
      settle();
      chk("r14_count_b", 64'(count), 64'd1);
      chk("r14_next_id", 64'(inst_id), 64'd11);
      chk("r14_next_op1", op[1], 64'h61);
      step();

      // flush overrides dispatch and issue
      fu_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         drive(6'(20 + k), 3'b111, 3'b111, 6'd0, 64'h0);
         step();
      end
      settle();
      chk("r20_count3", 64'(count), 64'd3);
      drive(6'd30, 3'b111, 3'b111, 6'd0, 64'h0);
      fu_ready = 1'b1;
      flush = 1'b1;
      settle();
      chk("r20_flush_valid", 64'(inst_valid), 64'd0);
      chk("r20_flush_ready", 64'(in_ready), 64'd0);
      step();
      flush = 1'b0; in_valid = 1'b0;
      settle();
      chk("r20_flushed_count", 64'(count), 64'd0);
      chk("r20_flushed_valid", 64'(inst_valid), 64'd0);

      // asynchronous reset with a ready entry pending
      drive(6'd33, 3'b111, 3'b111, 6'd0, 64'h77);
      step();
      in_valid = 1'b0;
      settle();
      chk("rst_pre_valid", 64'(inst_valid), 64'd1);
      rst = 1'b1;
      #1;
      chk("rst_async_valid", 64'(inst_valid), 64'd0);
      chk("rst_async_id", 64'(inst_id), 64'd0);
      chk("rst_async_op0", op[0], 64'd0);
      chk("rst_async_count", 64'(count), 64'd0);
      step();
      rst = 1'b0;
      settle();
      chk("rst_release_ready", 64'(in_ready), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
